// File: rtl/spi_regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_regfile_ctrl
// Brief    : System-clock register file behind the SPI slave, with an
//            arbitrated internal write port.
// Revision : 1.0
// ============================================================================
module spi_regfile_ctrl #(
  parameter int ADRSIZE     = 8,
  parameter int DATASIZE    = 32,
  parameter int NREGS       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_adr_latched,
  input  logic                      spi_data_latched,
  input  logic [ADRSIZE-1:0]        spi_adr,
  input  logic [DATASIZE-1:0]       spi_data_wr,
  output logic [DATASIZE-1:0]       spi_data_rd,
  input  logic                      int_wr_req,
  input  logic [ADRSIZE-2:0]        int_wr_idx,
  input  logic [DATASIZE-1:0]       int_wr_data,
  output logic                      int_wr_ack,
  output logic [NREGS*DATASIZE-1:0] regs,
  output logic                      wr_strobe,
  output logic [ADRSIZE-2:0]        wr_idx,
  output logic [7:0]                err_count
);

  localparam int                 c_IW    = ADRSIZE - 1;
  localparam int                 c_AW    = $clog2(NREGS);
  localparam logic [ADRSIZE-1:0] c_NREGS = ADRSIZE'(NREGS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD       = 2'd1,
    WAIT_DAT = 2'd2,
    WR       = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [SYNC_STAGES-1:0] r_adr_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic [SYNC_STAGES-1:0] r_primed;
  logic                  r_adr_hist;
  logic                  r_dat_hist;
  logic [c_IW-1:0]       r_idx;
  logic                  r_wflag;
  logic [DATASIZE-1:0]   r_regs [NREGS];
  logic [DATASIZE-1:0]   r_data_rd;
  logic                  r_int_ack;
  logic                  r_wr_strobe;
  logic [c_IW-1:0]       r_wr_idx;
  logic [7:0]            r_err;

  logic w_adr_s, w_dat_s, w_adr_rise, w_dat_rise;
  logic w_idx_ok, w_int_ok, w_int_acc, w_spi_wr, w_int_wr;

  assign w_adr_s    = r_adr_sync[SYNC_STAGES-1];
  assign w_dat_s    = r_dat_sync[SYNC_STAGES-1];
  assign w_adr_rise = w_adr_s & ~r_adr_hist;
  assign w_dat_rise = w_dat_s & ~r_dat_hist;
  assign w_idx_ok   = ({1'b0, r_idx} < c_NREGS);
  assign w_int_ok   = ({1'b0, int_wr_idx} < c_NREGS);
  assign w_int_acc  = int_wr_req & ~r_int_ack & (r_state != WR);
  assign w_spi_wr   = (r_state == WR) & w_idx_ok;
  assign w_int_wr   = w_int_acc & w_int_ok;

  // History stays high until the chain holds real samples, so a strobe
  // already high at reset release never looks like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr_sync <= '0;
      r_dat_sync <= '0;
      r_primed   <= '0;
      r_adr_hist <= 1'b1;
      r_dat_hist <= 1'b1;
    end else begin
      r_adr_sync <= {r_adr_sync[SYNC_STAGES-2:0], spi_adr_latched};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], spi_data_latched};
      r_primed   <= {r_primed[SYNC_STAGES-2:0], 1'b1};
      r_adr_hist <= r_primed[SYNC_STAGES-1] ? w_adr_s : 1'b1;
      r_dat_hist <= r_primed[SYNC_STAGES-1] ? w_dat_s : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_adr_rise) w_next = RD;
      RD:       w_next = WAIT_DAT;
      WAIT_DAT: begin
        if (w_dat_rise)    w_next = r_wflag ? WR : IDLE;
        else if (!w_adr_s) w_next = IDLE;
      end
      WR:       w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_idx       <= '0;
      r_wflag     <= 1'b0;
      r_data_rd   <= '0;
      r_int_ack   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_idx    <= '0;
      r_err       <= '0;
    end else begin
      if (r_state == IDLE && w_adr_rise) begin
        r_idx   <= spi_adr[c_IW-1:0];
        r_wflag <= spi_adr[ADRSIZE-1];
      end
      if (r_state == RD) begin
        r_data_rd <= w_idx_ok ? r_regs[r_idx[c_AW-1:0]] : '0;
        if (!w_idx_ok && r_err != 8'hFF) r_err <= r_err + 8'd1;
      end
      if (w_spi_wr) begin
        r_regs[r_idx[c_AW-1:0]] <= spi_data_wr;
        r_wr_idx                <= r_idx;
      end else if (w_int_wr) begin
        r_regs[int_wr_idx[c_AW-1:0]] <= int_wr_data;
        r_wr_idx                     <= int_wr_idx;
      end
      r_int_ack   <= w_int_acc;
      r_wr_strobe <= w_spi_wr | w_int_wr;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs[g*DATASIZE +: DATASIZE] = r_regs[g];
  end

  assign spi_data_rd = r_data_rd;
  assign int_wr_ack  = r_int_ack;
  assign wr_strobe   = r_wr_strobe;
  assign wr_idx      = r_wr_idx;
  assign err_count   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_regfile_ctrl
// Brief    : Directed and randomized SPI/internal traffic against a register model.
// Revision : 1.0
// ============================================================================
module tb_spi_regfile_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         spi_adr_latched = 1'b0;
  logic         spi_data_latched = 1'b0;
  logic [7:0]   spi_adr = '0;
  logic [31:0]  spi_data_wr = '0;
  logic [31:0]  spi_data_rd;
  logic         int_wr_req = 1'b0;
  logic [6:0]   int_wr_idx = '0;
  logic [31:0]  int_wr_data = '0;
  logic         int_wr_ack;
  logic [511:0] regs;
  logic         wr_strobe;
  logic [6:0]   wr_idx;
  logic [7:0]   err_count;

  logic [31:0] model [16];
  int          model_err = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  spi_regfile_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .spi_adr_latched(spi_adr_latched), .spi_data_latched(spi_data_latched),
    .spi_adr(spi_adr), .spi_data_wr(spi_data_wr), .spi_data_rd(spi_data_rd),
    .int_wr_req(int_wr_req), .int_wr_idx(int_wr_idx), .int_wr_data(int_wr_data),
    .int_wr_ack(int_wr_ack), .regs(regs), .wr_strobe(wr_strobe),
    .wr_idx(wr_idx), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] reg_of(input int i);
    return regs[i*32 +: 32];
  endfunction

  task automatic chk_regs(input string tag);
    int bad = 0;
    for (int i = 0; i < 16; i++) if (reg_of(i) !== model[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = '0;
    model_err = 0;
  endtask

  // Address phase of a frame; read data is due four clocks after the strobe.
  task automatic addr_phase(input logic [7:0] adr);
    logic [31:0] exp;
    exp = (adr[6:0] < 16) ? model[adr[3:0]] : 32'h0;
    if (adr[6:0] >= 16 && model_err < 255) model_err++;
    spi_adr = adr;
    spi_adr_latched = 1'b1;
    repeat (4) tick();
    chk("rd_data", spi_data_rd, exp);
    chk("err_count", {24'h0, err_count}, model_err);
  endtask

  // Data phase; optionally raises an internal request while the FSM is in WR.
  task automatic data_phase(input logic [31:0] wdata, input bit inj,
                            input logic [6:0] iidx, input logic [31:0] idata);
    bit wf, ok;
    wf = spi_adr[7];
    ok = spi_adr[6:0] < 16;
    spi_data_wr = wdata;
    spi_data_latched = 1'b1;
    repeat (3) tick();
    if (inj) begin
      int_wr_req = 1'b1; int_wr_idx = iidx; int_wr_data = idata;
    end
    tick();
    if (wf && ok) model[spi_adr[3:0]] = wdata;
    chk("spi_wr_strobe", wr_strobe, wf && ok);
    if (wf && ok) chk("spi_wr_idx", wr_idx, spi_adr[6:0]);
    chk_regs("regs_after_frame");
    if (inj) begin
      chk("int_ack_deferred", int_wr_ack, 0);
      tick();
      if (iidx < 16) model[iidx[3:0]] = idata;
      chk("int_ack_after_wr", int_wr_ack, 1);
      chk_regs("regs_after_int");
      int_wr_req = 1'b0;
    end
    spi_adr_latched = 1'b0;
    spi_data_latched = 1'b0;
    repeat (6) tick();
  endtask

  task automatic int_write(input logic [6:0] idx, input logic [31:0] data);
    int lat = 0;
    int_wr_req = 1'b1; int_wr_idx = idx; int_wr_data = data;
    do begin tick(); lat++; end while (!int_wr_ack && lat < 8);
    chk("int_ack_latency", lat, 1);
    if (idx < 16) begin
      model[idx[3:0]] = data;
      chk("int_wr_strobe", wr_strobe, 1);
      chk("int_wr_idx", wr_idx, idx);
    end
    chk_regs("regs_int");
    chk("int_err_unchanged", {24'h0, err_count}, model_err);
    int_wr_req = 1'b0;
    tick();
    chk("int_ack_pulse", int_wr_ack, 0);
  endtask

  initial begin
    logic [31:0] old;
    logic [7:0]  a;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rd", spi_data_rd, 0);
    chk("rst_err", {24'h0, err_count}, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_ack", int_wr_ack, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk_regs("rst_regs");

    addr_phase(8'h03); data_phase(32'h0, 0, 0, 0);
    addr_phase(8'h85); data_phase(32'hDEADBEEF, 0, 0, 0);
    addr_phase(8'h05); data_phase(32'h0, 0, 0, 0);
    addr_phase(8'h87); data_phase(32'hCAFE0007, 1, 7'd2, 32'h1234);
    addr_phase(8'h02); data_phase(32'h0, 0, 0, 0);
    addr_phase(8'h40); data_phase(32'h0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      a = {1'($urandom), 7'($urandom_range(0, 19))};
      addr_phase(a);
      data_phase($urandom, a[7] && ($urandom_range(0, 3) == 0), 7'($urandom_range(0, 19)), $urandom);
      if ($urandom_range(0, 2) == 0) int_write(7'($urandom_range(0, 19)), $urandom);
    end

    int_write(7'd4, 32'h44440000);
    old = model[4];
    addr_phase(8'h04);
    int_write(7'd4, 32'hA5A5A5A5);
    chk("snapshot_hold", spi_data_rd, old);
    data_phase(32'h0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      addr_phase(8'h40);
      data_phase(32'h0, 0, 0, 0);
    end
    chk("err_saturated", {24'h0, err_count}, 255);

    spi_adr = 8'h40;
    spi_adr_latched = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    model_reset();
    chk("midrst_regs_cleared", reg_of(5), 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("midrst_no_rd", {24'h0, err_count}, 0);
    chk_regs("midrst_regs");
    spi_adr_latched = 1'b0;
    repeat (6) tick();
    addr_phase(8'h89); data_phase(32'h0BADF00D, 0, 0, 0);
    addr_phase(8'h09); data_phase(32'h0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
